// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared memory-bus request type, arbiter states and byte-lane constants.
package cpu_bus_pkg;
   typedef struct packed {
      logic [19:1] addr;
      logic [15:0] data;
      logic        wr_en;
      logic [1:0]  bytesel;
   } mem_req_t;

   typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT_D, ARB_GRANT_I} arb_state_t;

   localparam logic [1:0] BYTESEL_WORD = 2'b11;
endpackage

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: merges the data and instruction ports onto one memory bus, one transaction at a time.
module mem_bus_arbiter
   import cpu_bus_pkg::*;
#(
   parameter bit ROUND_ROBIN = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [19:1] d_m_addr,
   input  logic [15:0] d_m_data_out,
   input  logic        d_m_access,
   input  logic        d_m_wr_en,
   input  logic [1:0]  d_m_bytesel,
   output logic        d_m_ack,
   input  logic [19:1] i_m_addr,
   input  logic        i_m_access,
   output logic        i_m_ack,
   output logic [15:0] m_data_in,
   output logic [19:1] q_m_addr,
   output logic [15:0] q_m_data_out,
   output logic        q_m_access,
   output logic        q_m_wr_en,
   output logic [1:0]  q_m_bytesel,
   input  logic        q_m_ack,
   input  logic [15:0] q_m_data_in,
   output logic        data_granted
);
   arb_state_t r_state;
   mem_req_t   r_req;
   logic       r_access;
   logic       r_last_d;
   logic       w_pick_d;
   mem_req_t   w_win;

   // On a tie in round-robin mode the data port yields only if it was served last.
   always_comb begin
      w_pick_d = d_m_access & (~i_m_access | ~ROUND_ROBIN | ~r_last_d);
      w_win    = w_pick_d ? mem_req_t'{addr: d_m_addr, data: d_m_data_out, wr_en: d_m_wr_en, bytesel: d_m_bytesel}
                          : mem_req_t'{addr: i_m_addr, data: 16'h0, wr_en: 1'b0, bytesel: BYTESEL_WORD};
      d_m_ack  = q_m_ack & (r_state == ARB_GRANT_D);
      i_m_ack  = q_m_ack & (r_state == ARB_GRANT_I);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ARB_IDLE;
         r_req    <= '0;
         r_access <= 1'b0;
         r_last_d <= 1'b0;
      end else if (r_state == ARB_IDLE) begin
         if (d_m_access | i_m_access) begin
            r_state  <= w_pick_d ? ARB_GRANT_D : ARB_GRANT_I;
            r_req    <= w_win;
            r_access <= 1'b1;
         end
      end else if (q_m_ack) begin
         r_state  <= ARB_IDLE;
         r_req    <= '0;
         r_access <= 1'b0;
         r_last_d <= (r_state == ARB_GRANT_D);
      end
   end

   assign m_data_in    = q_m_data_in;
   assign q_m_addr     = r_req.addr;
   assign q_m_data_out = r_req.data;
   assign q_m_wr_en    = r_req.wr_en;
   assign q_m_bytesel  = r_req.bytesel;
   assign q_m_access   = r_access;
   assign data_granted = (r_state == ARB_GRANT_D);
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: checks both tie-break modes against a transaction-level model of the arbiter.
module tb_mem_bus_arbiter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst [2];
   logic [19:1] d_addr [2];
   logic [15:0] d_wdata [2];
   logic        d_acc [2];
   logic        d_wr [2];
   logic [1:0]  d_bs [2];
   logic        d_ack [2];
   logic [19:1] i_addr [2];
   logic        i_acc [2];
   logic        i_ack [2];
   logic [15:0] m_din [2];
   logic [19:1] q_addr [2];
   logic [15:0] q_dout [2];
   logic        q_acc [2];
   logic        q_wr [2];
   logic [1:0]  q_bs [2];
   logic        q_ack [2];
   logic [15:0] q_din [2];
   logic        dg [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_bus_arbiter #(.ROUND_ROBIN(g == 1)) u_dut (
         .clk(clk), .reset(rst[g]),
         .d_m_addr(d_addr[g]), .d_m_data_out(d_wdata[g]), .d_m_access(d_acc[g]),
         .d_m_wr_en(d_wr[g]), .d_m_bytesel(d_bs[g]), .d_m_ack(d_ack[g]),
         .i_m_addr(i_addr[g]), .i_m_access(i_acc[g]), .i_m_ack(i_ack[g]),
         .m_data_in(m_din[g]),
         .q_m_addr(q_addr[g]), .q_m_data_out(q_dout[g]), .q_m_access(q_acc[g]),
         .q_m_wr_en(q_wr[g]), .q_m_bytesel(q_bs[g]), .q_m_ack(q_ack[g]),
         .q_m_data_in(q_din[g]), .data_granted(dg[g])
      );
   end

   int errors = 0;
   int checks = 0;

   // Model: who owns the bus (0 none, 1 data, 2 instr), who was served last, and the bus request it drives.
   int          own [2];
   int          last [2];
   logic [19:1] e_addr [2];
   logic [15:0] e_data [2];
   logic        e_wr [2];
   logic [1:0]  e_bs [2];
   logic        acked_d [2];
   logic        acked_i [2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset(input int k);
      own[k] = 0;
      last[k] = 2;
      e_addr[k] = '0;
      e_data[k] = '0;
      e_wr[k] = 1'b0;
      e_bs[k] = '0;
      acked_d[k] = 1'b0;
      acked_i[k] = 1'b0;
   endtask

   task automatic check_outputs(input int k);
      chk($sformatf("q_m_access[%0d]", k), q_acc[k], own[k] != 0);
      chk($sformatf("q_m_addr[%0d]", k), q_addr[k], e_addr[k]);
      chk($sformatf("q_m_data_out[%0d]", k), q_dout[k], e_data[k]);
      chk($sformatf("q_m_wr_en[%0d]", k), q_wr[k], e_wr[k]);
      chk($sformatf("q_m_bytesel[%0d]", k), q_bs[k], e_bs[k]);
      chk($sformatf("d_m_ack[%0d]", k), d_ack[k], q_ack[k] && own[k] == 1);
      chk($sformatf("i_m_ack[%0d]", k), i_ack[k], q_ack[k] && own[k] == 2);
      chk($sformatf("m_data_in[%0d]", k), m_din[k], q_din[k]);
      chk($sformatf("data_granted[%0d]", k), dg[k], own[k] == 1);
   endtask

   task automatic model_edge(input int k);
      bit take_d;
      acked_d[k] = own[k] == 1 && q_ack[k];
      acked_i[k] = own[k] == 2 && q_ack[k];
      if (rst[k]) model_reset(k);
      else if (own[k] == 0) begin
         if (d_acc[k] || i_acc[k]) begin
            take_d = d_acc[k] && !(i_acc[k] && k == 1 && last[k] == 1);
            own[k] = take_d ? 1 : 2;
            e_addr[k] = take_d ? d_addr[k] : i_addr[k];
            e_data[k] = take_d ? d_wdata[k] : 16'h0;
            e_wr[k] = take_d && d_wr[k];
            e_bs[k] = take_d ? d_bs[k] : 2'b11;
         end
      end else if (q_ack[k]) begin
         last[k] = own[k];
         own[k] = 0;
         e_addr[k] = '0;
         e_data[k] = '0;
         e_wr[k] = 1'b0;
         e_bs[k] = '0;
      end
   endtask

   task automatic step(input int k);
      #1 check_outputs(k);
      model_edge(k);
      @(negedge clk);
   endtask

   task automatic drive_rand(input int k);
      d_acc[k] = acked_d[k] ? ($urandom_range(0, 3) == 0) : !d_acc[k] ? ($urandom_range(0, 2) == 0)
               : !(own[k] != 1 && $urandom_range(0, 9) == 0);
      i_acc[k] = acked_i[k] ? ($urandom_range(0, 3) == 0) : !i_acc[k] ? ($urandom_range(0, 2) == 0)
               : !(own[k] != 2 && $urandom_range(0, 9) == 0);
      d_addr[k] = 19'($urandom);
      d_wdata[k] = 16'($urandom);
      d_wr[k] = 1'($urandom);
      d_bs[k] = 2'($urandom);
      i_addr[k] = 19'($urandom);
      q_ack[k] = own[k] != 0 ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      q_din[k] = 16'($urandom);
   endtask

   task automatic tie_test(input int k);
      d_acc[k] = 1'b1;
      i_acc[k] = 1'b1;
      d_wr[k] = 1'b0;
      d_bs[k] = 2'b11;
      for (int n = 0; n < 4; n++) begin
         d_addr[k] = 19'(16'h100 + n);
         i_addr[k] = 19'(16'h200 + n);
         q_ack[k] = 1'b0;
         step(k);
         chk($sformatf("tie_grant%0d[%0d]", n, k), dg[k], k == 0 || n % 2 == 0);
         q_ack[k] = 1'b1;
         step(k);
      end
      q_ack[k] = 1'b0;
      d_acc[k] = 1'b0;
      i_acc[k] = 1'b0;
      step(k);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1;
         d_addr[k] = '0; d_wdata[k] = '0; d_acc[k] = 1'b0; d_wr[k] = 1'b0; d_bs[k] = '0;
         i_addr[k] = '0; i_acc[k] = 1'b0; q_ack[k] = 1'b0; q_din[k] = '0;
         model_reset(k);
      end
      @(negedge clk);
      @(negedge clk);
      check_outputs(0);
      check_outputs(1);
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      @(negedge clk);

      tie_test(0);
      tie_test(1);

      d_addr[0] = 19'h1234; d_wr[0] = 1'b0; d_bs[0] = 2'b11; d_acc[0] = 1'b1;
      step(0);
      chk("t1_access", q_acc[0], 1);
      chk("t1_addr", q_addr[0], 19'h1234);
      q_ack[0] = 1'b1;
      q_din[0] = 16'hBEEF;
      #1;
      chk("t1_dack", d_ack[0], 1);
      chk("t1_rdata", m_din[0], 16'hBEEF);
      chk("t1_iack", i_ack[0], 0);
      step(0);
      d_acc[0] = 1'b0;
      q_ack[0] = 1'b0;
      step(0);

      d_addr[0] = 19'h7FFFF; d_wdata[0] = 16'hA55A; d_wr[0] = 1'b1; d_bs[0] = 2'b10; d_acc[0] = 1'b1;
      step(0);
      for (int n = 0; n < 4; n++) begin
         i_acc[0] = ~i_acc[0];
         i_addr[0] = 19'($urandom);
         d_addr[0] = 19'($urandom);
         step(0);
         chk("t4_hold_addr", q_addr[0], 19'h7FFFF);
      end
      i_acc[0] = 1'b1;
      q_ack[0] = 1'b1;
      #1 chk("t4_iack", i_ack[0], 0);
      step(0);
      d_acc[0] = 1'b0;
      q_ack[0] = 1'b0;
      step(0);
      chk("t4_instr_after", dg[0], 0);
      chk("t4_instr_access", q_acc[0], 1);
      q_ack[0] = 1'b1;
      step(0);
      i_acc[0] = 1'b0;
      q_ack[0] = 1'b0;
      step(0);

      i_addr[0] = 19'h0ABCD; i_acc[0] = 1'b1;
      step(0);
      step(0);
      #2 rst[0] = 1'b1;
      #1;
      chk("t5_access", q_acc[0], 0);
      chk("t5_addr", q_addr[0], 0);
      chk("t5_bytesel", q_bs[0], 0);
      chk("t5_dgrant", dg[0], 0);
      model_reset(0);
      i_acc[0] = 1'b0;
      @(negedge clk);
      step(0);
      rst[0] = 1'b0;
      i_addr[0] = 19'h05555; i_acc[0] = 1'b1;
      step(0);
      chk("t5_regrant", q_addr[0], 19'h05555);
      q_ack[0] = 1'b1;
      step(0);
      i_acc[0] = 1'b0;
      q_ack[0] = 1'b0;
      step(0);

      q_ack[0] = 1'b1;
      #1;
      chk("t6_dack", d_ack[0], 0);
      chk("t6_iack", i_ack[0], 0);
      step(0);
      q_ack[0] = 1'b0;
      chk("t6_idle", q_acc[0], 0);
      step(0);

      for (int k = 0; k < 2; k++) begin
         for (int n = 0; n < 1500; n++) begin
            drive_rand(k);
            step(k);
         end
         d_acc[k] = 1'b0;
         i_acc[k] = 1'b0;
         q_ack[k] = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
